// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operand forwarding at capture and detects load-use hazards.
// One instruction slot with valid/ready handshake on both sides and a saturating stall counter.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [63:0] in_pc,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_rs1_val,
    input  logic [63:0] in_rs2_val,
    input  logic [63:0] in_imm,
    input  logic        in_use_pc,
    input  logic        in_use_imm,
    input  logic        in_word32,
    input  logic [3:0]  in_aluctrl,
    input  logic        in_is_load,
    output logic        in_ready,
    input  logic        ex_fwd_valid,
    input  logic [4:0]  ex_fwd_rd,
    input  logic [63:0] ex_fwd_data,
    input  logic        ex_fwd_is_load,
    input  logic        mem_fwd_valid,
    input  logic [4:0]  mem_fwd_rd,
    input  logic [63:0] mem_fwd_data,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [63:0] out_a,
    output logic [63:0] out_b,
    output logic        out_word32,
    output logic [3:0]  out_aluctrl,
    output logic [4:0]  out_rd,
    output logic        out_is_load,
    output logic [63:0] out_store_data,
    output logic [31:0] stall_cnt
);

    logic        load_use;
    logic        capture;
    logic [63:0] rs1_res;
    logic [63:0] rs2_res;

    always_comb begin
        load_use = in_valid && ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != 5'd0) &&
                   ((ex_fwd_rd == in_rs1) || (ex_fwd_rd == in_rs2));
        in_ready = !flush && !load_use && (!out_valid || out_ready);
        capture  = in_valid && in_ready;
    end

    // A load in execute has no data yet, so it never forwards; load_use stalls instead.
    always_comb begin
        rs1_res = in_rs1_val;
        if (in_rs1 == 5'd0) begin
            rs1_res = 64'd0;
        end else if (ex_fwd_valid && !ex_fwd_is_load && (ex_fwd_rd == in_rs1)) begin
            rs1_res = ex_fwd_data;
        end else if (mem_fwd_valid && (mem_fwd_rd == in_rs1)) begin
            rs1_res = mem_fwd_data;
        end
    end

    always_comb begin
        rs2_res = in_rs2_val;
        if (in_rs2 == 5'd0) begin
            rs2_res = 64'd0;
        end else if (ex_fwd_valid && !ex_fwd_is_load && (ex_fwd_rd == in_rs2)) begin
            rs2_res = ex_fwd_data;
        end else if (mem_fwd_valid && (mem_fwd_rd == in_rs2)) begin
            rs2_res = mem_fwd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_a          <= 64'd0;
            out_b          <= 64'd0;
            out_store_data <= 64'd0;
            out_word32     <= 1'b0;
            out_aluctrl    <= 4'd0;
            out_rd         <= 5'd0;
            out_is_load    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid      <= 1'b1;
            out_a          <= in_use_pc ? in_pc : rs1_res;
            out_b          <= in_use_imm ? in_imm : rs2_res;
            out_store_data <= rs2_res;
            out_word32     <= in_word32;
            out_aluctrl    <= in_aluctrl;
            out_rd         <= in_rd;
            out_is_load    <= in_is_load;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (load_use && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for forwarding/operand selection,
// plus hand-written load-use, backpressure, flush and reset sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [63:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_pc, in_use_imm, in_word32;
    logic [3:0]  in_aluctrl;
    logic        in_is_load;
    logic        in_ready;
    logic        ex_fwd_valid;
    logic [4:0]  ex_fwd_rd;
    logic [63:0] ex_fwd_data;
    logic        ex_fwd_is_load;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_rd;
    logic [63:0] mem_fwd_data;
    logic        flush, out_ready;
    logic        out_valid;
    logic [63:0] out_a, out_b, out_store_data;
    logic        out_word32;
    logic [3:0]  out_aluctrl;
    logic [4:0]  out_rd;
    logic        out_is_load;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_pc(in_use_pc), .in_use_imm(in_use_imm), .in_word32(in_word32),
        .in_aluctrl(in_aluctrl), .in_is_load(in_is_load), .in_ready(in_ready),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .ex_fwd_is_load(ex_fwd_is_load),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_word32(out_word32),
        .out_aluctrl(out_aluctrl), .out_rd(out_rd), .out_is_load(out_is_load),
        .out_store_data(out_store_data), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] rs1_val, rs2_val, pc, imm;
        logic        use_pc, use_imm, word32;
        logic [3:0]  aluctrl;
        logic        is_load;
        logic        exv;
        logic [4:0]  exrd;
        logic [63:0] exdata;
        logic        exld;
        logic        memv;
        logic [4:0]  memrd;
        logic [63:0] memdata;
        logic [63:0] exp_a, exp_b, exp_sd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
        in_use_pc = 0; in_use_imm = 0; in_word32 = 0; in_aluctrl = 0; in_is_load = 0;
        ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_data = 0; ex_fwd_is_load = 0;
        mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic apply_vec(input vec_t v);
        in_valid = 1; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
        in_rs1_val = v.rs1_val; in_rs2_val = v.rs2_val; in_pc = v.pc; in_imm = v.imm;
        in_use_pc = v.use_pc; in_use_imm = v.use_imm; in_word32 = v.word32;
        in_aluctrl = v.aluctrl; in_is_load = v.is_load;
        ex_fwd_valid = v.exv; ex_fwd_rd = v.exrd; ex_fwd_data = v.exdata; ex_fwd_is_load = v.exld;
        mem_fwd_valid = v.memv; mem_fwd_rd = v.memrd; mem_fwd_data = v.memdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rs1 rs2 rd rs1v rs2v pc imm use_pc use_imm w32 alu ld | ex v rd data ld | mem v rd data | a b sd
        vecs[0] = '{5'd5, 5'd6, 5'd1, 64'h1, 64'h2, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0,
                    1'b1, 5'd5, 64'hAA, 1'b0, 1'b1, 5'd5, 64'hBB, 64'hAA, 64'h2, 64'h2};
        vecs[1] = '{5'd5, 5'd6, 5'd2, 64'h1, 64'h2, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0,
                    1'b0, 5'd5, 64'hAA, 1'b0, 1'b1, 5'd5, 64'hBB, 64'hBB, 64'h2, 64'h2};
        vecs[2] = '{5'd3, 5'd0, 5'd3, 64'h7, 64'h99, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1,
                    1'b1, 5'd0, 64'h55, 1'b0, 1'b0, 5'd0, 64'h0, 64'h7, 64'h0, 64'h0};
        vecs[3] = '{5'd4, 5'd8, 5'd4, 64'h9, 64'h33, 64'h1000, 64'h20, 1'b1, 1'b1, 1'b0, 4'h4,
                    1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h1000, 64'h20, 64'h33};
        vecs[4] = '{5'd10, 5'd10, 5'd5, 64'h111, 64'h111, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 4'h5,
                    1'b0, 1'b0, 5'd10, 64'hDEAD, 1'b0, 1'b0, 5'd10, 64'hBEEF,
                    64'h111, 64'h111, 64'h111};
        vecs[5] = '{5'd13, 5'd12, 5'd6, 64'h1, 64'h2, 64'h0, 64'h5, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0,
                    1'b1, 5'd13, 64'hDD, 1'b0, 1'b1, 5'd12, 64'hCC, 64'hDD, 64'h5, 64'hCC};
        vecs[6] = '{5'd3, 5'd4, 5'd31, 64'h30, 64'h40, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1,
                    1'b1, 5'd20, 64'hEE, 1'b1, 1'b1, 5'd21, 64'hFF, 64'h30, 64'h40, 64'h40};

        idle_inputs();
        rst = 1;
        #2;
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset out_a", out_a, 64'd0);
        check("reset out_b", out_b, 64'd0);
        check("reset out_store_data", out_store_data, 64'd0);
        check("reset out_rd", {59'd0, out_rd}, 64'd0);
        check("reset stall_cnt", {32'd0, stall_cnt}, 64'd0);
        @(negedge clk);
        rst = 0;

        // Back-to-back table vectors, out_ready held high
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1;
            check($sformatf("v%0d in_ready", i), {63'd0, in_ready}, 64'd1);
            tick();
            check($sformatf("v%0d out_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("v%0d out_a", i), out_a, vecs[i].exp_a);
            check($sformatf("v%0d out_b", i), out_b, vecs[i].exp_b);
            check($sformatf("v%0d out_store_data", i), out_store_data, vecs[i].exp_sd);
            check($sformatf("v%0d out_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].rd});
            check($sformatf("v%0d out_aluctrl", i), {60'd0, out_aluctrl}, {60'd0, vecs[i].aluctrl});
            check($sformatf("v%0d out_word32", i), {63'd0, out_word32}, {63'd0, vecs[i].word32});
            check($sformatf("v%0d out_is_load", i), {63'd0, out_is_load}, {63'd0, vecs[i].is_load});
        end
        @(negedge clk);
        idle_inputs();
        tick();
        check("drain out_valid", {63'd0, out_valid}, 64'd0);
        check("no stall yet", {32'd0, stall_cnt}, 64'd0);

        // Load-use stall for three cycles
        @(negedge clk);
        in_valid = 1; in_rs1 = 5'd2; in_rs2 = 5'd7; in_rd = 5'd9;
        in_rs1_val = 64'h22; in_rs2_val = 64'h77;
        ex_fwd_valid = 1; ex_fwd_rd = 5'd7; ex_fwd_is_load = 1; ex_fwd_data = 64'h1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("lu%0d in_ready", c), {63'd0, in_ready}, 64'd0);
            tick();
            check($sformatf("lu%0d out_valid", c), {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end
        check("lu stall_cnt", {32'd0, stall_cnt}, 64'd3);
        ex_fwd_valid = 0;
        #1;
        check("lu release in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("lu capture out_valid", {63'd0, out_valid}, 64'd1);
        check("lu capture out_b", out_b, 64'h77);
        check("lu capture out_a", out_a, 64'h22);
        check("lu stall_cnt hold", {32'd0, stall_cnt}, 64'd3);

        // Backpressure for two cycles, then transfer with simultaneous capture
        @(negedge clk);
        out_ready = 0;
        in_rs1 = 5'd1; in_rs1_val = 64'h1234; in_rs2 = 5'd3; in_rs2_val = 64'h5678;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("bp%0d in_ready", c), {63'd0, in_ready}, 64'd0);
            tick();
            check($sformatf("bp%0d out_valid", c), {63'd0, out_valid}, 64'd1);
            check($sformatf("bp%0d out_a", c), out_a, 64'h22);
            check($sformatf("bp%0d out_b", c), out_b, 64'h77);
            @(negedge clk);
        end
        out_ready = 1;
        #1;
        check("bp release in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("bp next out_valid", {63'd0, out_valid}, 64'd1);
        check("bp next out_a", out_a, 64'h1234);
        check("bp next out_b", out_b, 64'h5678);

        // Flush while held and stalled by a load-use: no capture, no stall count
        @(negedge clk);
        out_ready = 0; flush = 1;
        in_rs1 = 5'd11; in_rs1_val = 64'h9999;
        ex_fwd_valid = 1; ex_fwd_rd = 5'd11; ex_fwd_is_load = 1;
        #1;
        check("flush in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        check("flush out_valid", {63'd0, out_valid}, 64'd0);
        check("flush stall_cnt", {32'd0, stall_cnt}, 64'd3);

        // Capture then reset mid-cycle
        @(negedge clk);
        idle_inputs();
        in_valid = 1; in_rs1 = 5'd6; in_rs1_val = 64'h66;
        tick();
        check("pre-rst out_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 0;
        #2;
        rst = 1;
        #1;
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst stall_cnt", {32'd0, stall_cnt}, 64'd0);
        check("rst out_a", out_a, 64'd0);
        @(negedge clk);
        rst = 0;
        in_valid = 1; in_rs1 = 5'd6; in_rs1_val = 64'h6A;
        tick();
        check("post-rst out_valid", {63'd0, out_valid}, 64'd1);
        check("post-rst out_a", out_a, 64'h6A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
